// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    // FSM state encoding; values are fixed so waveforms decode consistently.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Latency down-counter width; covers LATENCY-1 for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    localparam int unsigned LATENCY_DEFAULT = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: two master request ports, hold/busy and the memory port.
interface mem_arbiter_if;

    logic        hold;
    logic        m0_strobe;
    logic        m1_strobe;
    logic        m0_rw;
    logic        m1_rw;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        m0_ack;
    logic        m1_ack;
    logic        busy;
    logic        s_strobe;
    logic        s_rw;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;

    // Arbiter view: serves the masters, drives the memory port.
    modport slave (
        input  hold, m0_strobe, m1_strobe, m0_rw, m1_rw,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        output m0_rdata, m1_rdata, m0_ack, m1_ack, busy,
        output s_strobe, s_rw, s_addr, s_wdata
    );

    // Environment view: the requesting masters plus the memory device.
    modport master (
        output hold, m0_strobe, m1_strobe, m0_rw, m1_rw,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        input  m0_rdata, m1_rdata, m0_ack, m1_ack, busy,
        input  s_strobe, s_rw, s_addr, s_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser; gnt is the index of the winning requester.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    // Lone requester wins; under contention the one that did not win last time wins.
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter: one access in flight, fair alternation, one-cycle ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_last;
    logic             r_grant;
    logic             r_rw;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             w_gnt;
    logic             w_valid;
    logic             w_start;
    logic             w_active;
    logic             w_done;

    rr_pick2 u_pick (
        .req   ({bus.m1_strobe, bus.m0_strobe}),
        .last  (r_last),
        .gnt   (w_gnt),
        .valid (w_valid)
    );

    // Next-state and latency counter; the counter runs through ISSUE and WAIT.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!bus.hold && w_valid) begin
                    w_start   = 1'b1;
                    w_state_d = StIssue;
                    w_cnt_d   = CntLoad;
                end
            end
            StIssue: begin
                w_state_d = (LATENCY == 1) ? StDone : StWait;
                if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Grant and request fields are captured only on the IDLE->ISSUE edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_last  <= w_gnt;
            r_grant <= w_gnt;
            r_rw    <= w_gnt ? bus.m1_rw    : bus.m0_rw;
            r_addr  <= w_gnt ? bus.m1_addr  : bus.m0_addr;
            r_wdata <= w_gnt ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    // Outputs decode from state and latches; rdata is a gated passthrough of s_rdata.
    always_comb begin
        w_active     = (r_state != StIdle);
        w_done       = (r_state == StDone);
        bus.busy     = w_active;
        bus.s_strobe = (r_state == StIssue);
        bus.s_rw     = w_active & r_rw;
        bus.s_addr   = w_active ? r_addr  : '0;
        bus.s_wdata  = w_active ? r_wdata : '0;
        bus.m0_ack   = w_done & ~r_grant;
        bus.m1_ack   = w_done &  r_grant;
        bus.m0_rdata = bus.m0_ack ? bus.s_rdata : '0;
        bus.m1_rdata = bus.m1_ack ? bus.s_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios then random traffic on LATENCY=1 and LATENCY=3 copies.
module tb_mem_arbiter;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic chk_en  = 1'b0;
    int   n_tests = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    // Index 0 drives the LATENCY=1 arbiter, index 1 the LATENCY=3 arbiter.
    logic        t_hold [2];
    logic        t_st0  [2];
    logic        t_st1  [2];
    logic        t_rw0  [2];
    logic        t_rw1  [2];
    logic [31:0] t_a0   [2];
    logic [31:0] t_a1   [2];
    logic [31:0] t_wd0  [2];
    logic [31:0] t_wd1  [2];
    logic [31:0] mem    [256];

    mem_arbiter_if bus1 ();
    mem_arbiter_if bus3 ();

    assign bus1.hold      = t_hold[0];
    assign bus1.m0_strobe = t_st0[0];
    assign bus1.m1_strobe = t_st1[0];
    assign bus1.m0_rw     = t_rw0[0];
    assign bus1.m1_rw     = t_rw1[0];
    assign bus1.m0_addr   = t_a0[0];
    assign bus1.m1_addr   = t_a1[0];
    assign bus1.m0_wdata  = t_wd0[0];
    assign bus1.m1_wdata  = t_wd1[0];
    assign bus1.s_rdata   = mem[bus1.s_addr[7:0]];

    assign bus3.hold      = t_hold[1];
    assign bus3.m0_strobe = t_st0[1];
    assign bus3.m1_strobe = t_st1[1];
    assign bus3.m0_rw     = t_rw0[1];
    assign bus3.m1_rw     = t_rw1[1];
    assign bus3.m0_addr   = t_a0[1];
    assign bus3.m1_addr   = t_a1[1];
    assign bus3.m0_wdata  = t_wd0[1];
    assign bus3.m1_wdata  = t_wd1[1];
    assign bus3.s_rdata   = mem[bus3.s_addr[7:0]];

    mem_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    mem_arbiter #(.LATENCY(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    // Reference model: m_age counts cycles since the grant (0 = idle).
    // Strobe at age 1, ack at age LATENCY+1, idle again the cycle after.
    int          m_age  [2] = '{0, 0};
    logic        m_last [2];
    logic        m_gnt  [2];
    logic        m_rw   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic pick(input int d);
        if (t_st0[d] && t_st1[d]) return !m_last[d];
        return t_st1[d];
    endfunction

    function automatic logic exp_ack(input int d, input logic m);
        return (m_age[d] == lat(d) + 1) && (m_gnt[d] == m);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_age[d]  <= 0;
                m_last[d] <= 1'b1;
            end else if (m_age[d] != 0) begin
                m_age[d] <= (m_age[d] == lat(d) + 1) ? 0 : m_age[d] + 1;
            end else if (!t_hold[d] && (t_st0[d] || t_st1[d])) begin
                m_age[d]  <= 1;
                m_last[d] <= pick(d);
                m_gnt[d]  <= pick(d);
                m_rw[d]   <= pick(d) ? t_rw1[d] : t_rw0[d];
                m_addr[d] <= pick(d) ? t_a1[d]  : t_a0[d];
                m_wd[d]   <= pick(d) ? t_wd1[d] : t_wd0[d];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
            $error("%s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input int d, input logic busy, input logic sstb, input logic srw,
                             input logic [31:0] saddr, input logic [31:0] swd,
                             input logic ack0, input logic ack1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
        logic        act;
        logic        ea0;
        logic        ea1;
        logic [31:0] rdv;
        act = (m_age[d] != 0);
        ea0 = exp_ack(d, 1'b0);
        ea1 = exp_ack(d, 1'b1);
        rdv = mem[m_addr[d][7:0]];
        chk($sformatf("L%0d busy", lat(d)), 32'(busy), 32'(act));
        chk($sformatf("L%0d s_strobe", lat(d)), 32'(sstb), 32'(m_age[d] == 1));
        chk($sformatf("L%0d s_rw", lat(d)), 32'(srw), 32'(act && m_rw[d]));
        chk($sformatf("L%0d s_addr", lat(d)), saddr, act ? m_addr[d] : 32'h0);
        chk($sformatf("L%0d s_wdata", lat(d)), swd, act ? m_wd[d] : 32'h0);
        chk($sformatf("L%0d m0_ack", lat(d)), 32'(ack0), 32'(ea0));
        chk($sformatf("L%0d m1_ack", lat(d)), 32'(ack1), 32'(ea1));
        chk($sformatf("L%0d m0_rdata", lat(d)), rd0, ea0 ? rdv : 32'h0);
        chk($sformatf("L%0d m1_rdata", lat(d)), rd1, ea1 ? rdv : 32'h0);
    endtask

    // Every cycle, both arbiters are compared against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check_bus(0, bus1.busy, bus1.s_strobe, bus1.s_rw, bus1.s_addr, bus1.s_wdata,
                      bus1.m0_ack, bus1.m1_ack, bus1.m0_rdata, bus1.m1_rdata);
            check_bus(1, bus3.busy, bus3.s_strobe, bus3.s_rw, bus3.s_addr, bus3.s_wdata,
                      bus3.m0_ack, bus3.m1_ack, bus3.m0_rdata, bus3.m1_rdata);
        end
    end

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            t_hold[d] = 1'b0;
            t_st0[d]  = 1'b0;
            t_st1[d]  = 1'b0;
            t_rw0[d]  = 1'b0;
            t_rw1[d]  = 1'b0;
            t_a0[d]   = '0;
            t_a1[d]   = '0;
            t_wd0[d]  = '0;
            t_wd1[d]  = '0;
        end
    endtask

    task automatic do_reset();
        clr();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic new_req(input int d, input int m);
        if (m == 0) begin
            t_st0[d] = 1'b1;
            t_rw0[d] = 1'($urandom_range(0, 1));
            t_a0[d]  = $urandom;
            t_wd0[d] = $urandom;
        end else begin
            t_st1[d] = 1'b1;
            t_rw1[d] = 1'($urandom_range(0, 1));
            t_a1[d]  = $urandom;
            t_wd1[d] = $urandom;
        end
    endtask

    // Random master: holds strobe until ack, then drops it or issues a new request.
    task automatic drive_master(input int d, input int m);
        logic st;
        st = (m == 0) ? t_st0[d] : t_st1[d];
        if (st && exp_ack(d, m[0])) begin
            if ($urandom_range(0, 1) == 1) begin
                new_req(d, m);
            end else if (m == 0) begin
                t_st0[d] = 1'b0;
            end else begin
                t_st1[d] = 1'b0;
            end
        end else if (st) begin
            // Late address changes must not reach the memory port once granted.
            if ($urandom_range(0, 7) == 0) begin
                if (m == 0) t_a0[d] = $urandom;
                else        t_a1[d] = $urandom;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            new_req(d, m);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h20] = 32'h0BAD_F00D;
        clr();
        reset_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", 32'(bus1.busy), 32'h0);
        chk("reset s_strobe", 32'(bus3.s_strobe), 32'h0);
        chk("reset s_addr", bus3.s_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single master 0 read at LATENCY=1.
        t_st0[0] = 1'b1;
        t_a0[0]  = 32'h10;
        @(negedge clk);
        chk("t1 s_strobe", 32'(bus1.s_strobe), 32'h1);
        chk("t1 s_addr", bus1.s_addr, 32'h10);
        chk("t1 early ack", 32'(bus1.m0_ack), 32'h0);
        @(negedge clk);
        chk("t1 m0_ack", 32'(bus1.m0_ack), 32'h1);
        chk("t1 m0_rdata", bus1.m0_rdata, 32'hDEAD_BEEF);
        chk("t1 m1_ack", 32'(bus1.m1_ack), 32'h0);
        t_st0[0] = 1'b0;
        @(negedge clk);
        chk("t1 back idle", 32'(bus1.busy), 32'h0);

        // Contention after reset: m0, m1, m0, three cycles each.
        do_reset();
        t_st0[0] = 1'b1;
        t_st1[0] = 1'b1;
        t_a0[0]  = 32'h100;
        t_a1[0]  = 32'h104;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) chk("t2 first grant addr", bus1.s_addr, 32'h100);
            if (i == 4) chk("t2 second grant addr", bus1.s_addr, 32'h104);
            chk($sformatf("t2 m0_ack c%0d", i), 32'(bus1.m0_ack), 32'(i == 2 || i == 8));
            chk($sformatf("t2 m1_ack c%0d", i), 32'(bus1.m1_ack), 32'(i == 5));
        end

        // LATENCY=3 write from master 1.
        do_reset();
        t_st1[1] = 1'b1;
        t_rw1[1] = 1'b1;
        t_a1[1]  = 32'h200;
        t_wd1[1] = 32'h1234_5678;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("t3 s_strobe", 32'(bus3.s_strobe), 32'h1);
                chk("t3 s_rw", 32'(bus3.s_rw), 32'h1);
                chk("t3 s_wdata", bus3.s_wdata, 32'h1234_5678);
                chk("t3 s_addr", bus3.s_addr, 32'h200);
            end
            chk($sformatf("t3 busy c%0d", i), 32'(bus3.busy), 32'(i <= 4));
            chk($sformatf("t3 m1_ack c%0d", i), 32'(bus3.m1_ack), 32'(i == 4));
            if (i == 4) t_st1[1] = 1'b0;
        end

        // Hold raised during WAIT: current access completes, m1 waits for hold to drop.
        do_reset();
        t_st0[1] = 1'b1;
        t_a0[1]  = 32'h30;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 2) begin
                t_hold[1] = 1'b1;
                t_st1[1]  = 1'b1;
                t_a1[1]   = 32'h40;
            end
            if (i == 4) begin
                chk("t4 m0_ack under hold", 32'(bus3.m0_ack), 32'h1);
                t_st0[1] = 1'b0;
            end
            if (i >= 5 && i <= 7) chk($sformatf("t4 held c%0d", i), 32'(bus3.busy), 32'h0);
            if (i == 7) t_hold[1] = 1'b0;
            if (i == 8) begin
                chk("t4 strobe after hold", 32'(bus3.s_strobe), 32'h1);
                chk("t4 addr after hold", bus3.s_addr, 32'h40);
            end
            if (i == 11) begin
                chk("t4 m1_ack", 32'(bus3.m1_ack), 32'h1);
                t_st1[1] = 1'b0;
            end
        end

        // Reset during WAIT aborts without ack; a fresh issue follows release.
        do_reset();
        t_st0[1] = 1'b1;
        t_a0[1]  = 32'h50;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b0;
            if (i == 3) begin
                chk("t5 busy after reset", 32'(bus3.busy), 32'h0);
                chk("t5 s_addr after reset", bus3.s_addr, 32'h0);
                chk("t5 no ack after reset", 32'(bus3.m0_ack), 32'h0);
                reset_n = 1'b1;
            end
            if (i == 4) begin
                chk("t5 fresh issue", 32'(bus3.s_strobe), 32'h1);
                chk("t5 no stale ack", 32'(bus3.m0_ack), 32'h0);
            end
            if (i == 7) begin
                chk("t5 fresh ack", 32'(bus3.m0_ack), 32'h1);
                t_st0[1] = 1'b0;
            end
        end

        // Address change during WAIT is ignored.
        do_reset();
        t_st0[1] = 1'b1;
        t_a0[1]  = 32'h10;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t6 s_addr c%0d", i), bus3.s_addr, 32'h10);
            if (i == 2) t_a0[1] = 32'h20;
            if (i == 4) begin
                chk("t6 m0_ack", 32'(bus3.m0_ack), 32'h1);
                chk("t6 m0_rdata", bus3.m0_rdata, 32'hDEAD_BEEF);
                t_st0[1] = 1'b0;
            end
        end

        // Random traffic with occasional hold and reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                drive_master(d, 0);
                drive_master(d, 1);
                t_hold[d] = ($urandom_range(0, 9) == 0);
            end
            reset_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
